// File: rtl/ifid_skid_buf.sv
// ifid_skid_buf: two-entry circular skid buffer between fetch and decode.
// Carries {pc, inst} pairs with valid/ready handshakes on both sides,
// drops in-flight entries on a redirect flush, and drives every output
// from a register (no out_ready -> in_ready combinational path).
// Optional build macro: IFID_PERF_EN adds stall_cnt/bubble_cnt counters.
module ifid_skid_buf #(
    parameter int unsigned PC_W   = 64,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
`ifdef IFID_PERF_EN
    ,
    output logic [63:0]       stall_cnt,
    output logic [63:0]       bubble_cnt
`endif
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [PC_W-1:0]   pc_d   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [INST_W-1:0] inst_d [DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_d;
    logic              out_valid_d;
    logic [PC_W-1:0]   out_pc_d;
    logic [INST_W-1:0] out_inst_d;
    logic              push;
    logic              pop;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Next-state: storage, pointers, occupancy and the registered outputs.
    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = CNT_W'(0);
        end else begin
            if (push) begin
                pc_d[wr_ptr_q]   = in_pc;
                inst_d[wr_ptr_q] = in_inst;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        in_ready_d  = (count_d != CNT_W'(DEPTH));
        out_valid_d = (count_d != CNT_W'(0));
        out_pc_d    = pc_d[rd_ptr_d];
        out_inst_d  = inst_d[rd_ptr_d];
    end

    // State register; reset clears storage and outputs and wins over flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= CNT_W'(0);
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_pc    <= out_pc_d;
            out_inst  <= out_inst_d;
        end
    end

`ifdef IFID_PERF_EN
    // Performance counters: cleared by reset only, free-running wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= 64'd0;
            bubble_cnt <= 64'd0;
        end else begin
            if (in_valid & ~in_ready) begin
                stall_cnt <= stall_cnt + 64'd1;
            end
            if (out_ready & ~out_valid) begin
                bubble_cnt <= bubble_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifid_skid_buf.sv
// Testbench for ifid_skid_buf: directed vector table, perf sequence (when
// IFID_PERF_EN is defined) and randomized traffic against a queue model.
module tb_ifid_skid_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
`ifdef IFID_PERF_EN
    logic [63:0] stall_cnt;
    logic [63:0] bubble_cnt;
`endif

    ifid_skid_buf #(.PC_W(64), .INST_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst)
`ifdef IFID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: a FIFO queue of at most two entries.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        mq[$];
    logic [63:0] m_stall  = 64'd0;
    logic [63:0] m_bubble = 64'd0;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic        e_chk;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [63:0] pc, input logic [31:0] inst,
                                input logic ordy, input logic e_ov, input logic e_ir,
                                input logic e_chk, input logic [63:0] e_pc,
                                input logic [31:0] e_inst);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_chk = e_chk; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, sample #1 later.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [63:0] pc, input logic [31:0] inst, input logic ordy);
        int  sz;
        logic acc_push;
        logic acc_pop;
        @(negedge clk);
        reset = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
        sz = mq.size();
        @(posedge clk);
        if (r) begin
            m_stall  = 64'd0;
            m_bubble = 64'd0;
        end else begin
            if (iv && sz == 2) m_stall = m_stall + 64'd1;
            if (ordy && sz == 0) m_bubble = m_bubble + 64'd1;
        end
        if (r || f) begin
            mq.delete();
        end else begin
            acc_push = iv && (sz < 2);
            acc_pop  = ordy && (sz > 0);
            if (acc_pop) void'(mq.pop_front());
            if (acc_push) mq.push_back('{pc: pc, inst: inst});
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, "_in_ready"},  64'(in_ready),  64'(mq.size() != 2));
        if (mq.size() != 0) begin
            check({tag, "_out_pc"},   out_pc,          mq[0].pc);
            check({tag, "_out_inst"}, 64'(out_inst),   64'(mq[0].inst));
        end
`ifdef IFID_PERF_EN
        check({tag, "_stall_cnt"},  stall_cnt,  m_stall);
        check({tag, "_bubble_cnt"}, bubble_cnt, m_bubble);
`endif
    endtask

    initial begin
        logic [63:0] cur_pc;
        logic [31:0] cur_inst;
        logic        iv, ordy, fl, rs, pend;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

        // Directed vectors; expectations are the outputs after the edge.
        //            rst fl iv pc            inst          ordy ov ir chk pc            inst
        vt.push_back(mk(1, 0, 0, 64'h0,        32'h0,        0,  0, 1, 1, 64'h0,        32'h0));
        vt.push_back(mk(1, 0, 0, 64'h0,        32'h0,        0,  0, 1, 1, 64'h0,        32'h0));
        vt.push_back(mk(0, 0, 0, 64'h0,        32'h0,        0,  0, 1, 1, 64'h0,        32'h0));
        vt.push_back(mk(0, 0, 1, 64'h80000000, 32'h00000413, 1,  1, 1, 1, 64'h80000000, 32'h00000413));
        vt.push_back(mk(0, 0, 1, 64'h80000004, 32'h00100073, 1,  1, 1, 1, 64'h80000004, 32'h00100073));
        vt.push_back(mk(0, 0, 1, 64'h80000008, 32'h00a00513, 1,  1, 1, 1, 64'h80000008, 32'h00a00513));
        vt.push_back(mk(0, 0, 0, 64'h0,        32'h0,        1,  0, 1, 0, 64'h0,        32'h0));
        vt.push_back(mk(0, 0, 1, 64'h80000000, 32'h00000001, 0,  1, 1, 1, 64'h80000000, 32'h00000001));
        vt.push_back(mk(0, 0, 1, 64'h80000004, 32'h00000002, 0,  1, 0, 1, 64'h80000000, 32'h00000001));
        vt.push_back(mk(0, 0, 1, 64'h80000008, 32'h00000003, 0,  1, 0, 1, 64'h80000000, 32'h00000001));
        vt.push_back(mk(0, 0, 1, 64'h80000008, 32'h00000003, 1,  1, 1, 1, 64'h80000004, 32'h00000002));
        vt.push_back(mk(0, 0, 1, 64'h80000008, 32'h00000003, 0,  1, 0, 1, 64'h80000004, 32'h00000002));
        vt.push_back(mk(0, 0, 0, 64'h0,        32'h0,        1,  1, 1, 1, 64'h80000008, 32'h00000003));
        vt.push_back(mk(0, 0, 0, 64'h0,        32'h0,        1,  0, 1, 0, 64'h0,        32'h0));
        vt.push_back(mk(0, 0, 1, 64'h80000010, 32'h00000004, 0,  1, 1, 1, 64'h80000010, 32'h00000004));
        vt.push_back(mk(0, 0, 1, 64'h80000014, 32'h00000005, 0,  1, 0, 1, 64'h80000010, 32'h00000004));
        vt.push_back(mk(0, 1, 1, 64'h8000000c, 32'h00000006, 1,  0, 1, 0, 64'h0,        32'h0));
        vt.push_back(mk(0, 0, 1, 64'h80000100, 32'h00000007, 0,  1, 1, 1, 64'h80000100, 32'h00000007));
        vt.push_back(mk(0, 0, 0, 64'h0,        32'h0,        1,  0, 1, 0, 64'h0,        32'h0));
        vt.push_back(mk(0, 0, 1, 64'h80000200, 32'h00000008, 0,  1, 1, 1, 64'h80000200, 32'h00000008));
        vt.push_back(mk(1, 0, 1, 64'h80000204, 32'h00000009, 0,  0, 1, 1, 64'h0,        32'h0));
        vt.push_back(mk(0, 0, 1, 64'h80000300, 32'h0000000a, 0,  1, 1, 1, 64'h80000300, 32'h0000000a));
        vt.push_back(mk(1, 1, 1, 64'h80000304, 32'h0000000b, 1,  0, 1, 1, 64'h0,        32'h0));

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].pc, vt[i].inst, vt[i].ordy);
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
            check($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vt[i].e_ir));
            if (vt[i].e_chk) begin
                check($sformatf("vec%0d_out_pc", i),   out_pc,        vt[i].e_pc);
                check($sformatf("vec%0d_out_inst", i), 64'(out_inst), 64'(vt[i].e_inst));
            end
        end

`ifdef IFID_PERF_EN
        step(1, 0, 0, 64'h0, 32'h0, 0);
        check("perf_reset_stall",  stall_cnt,  64'd0);
        check("perf_reset_bubble", bubble_cnt, 64'd0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 64'h0, 32'h0, 1);
        step(0, 0, 1, 64'h80000000, 32'h1, 0);
        step(0, 0, 1, 64'h80000004, 32'h2, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 64'h80000008, 32'h3, 0);
        check("perf_bubble3", bubble_cnt, 64'd3);
        check("perf_stall4",  stall_cnt,  64'd4);
        step(0, 1, 0, 64'h0, 32'h0, 0);
        check("perf_flush_bubble", bubble_cnt, 64'd3);
        check("perf_flush_stall",  stall_cnt,  64'd4);
        step(1, 0, 0, 64'h0, 32'h0, 0);
        check("perf_rst_bubble", bubble_cnt, 64'd0);
        check("perf_rst_stall",  stall_cnt,  64'd0);
`endif

        // Randomized traffic; an offer not accepted is held stable.
        cur_pc = 64'h80001000; cur_inst = $urandom(); pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rs   = ($urandom_range(0, 99) == 0);
            fl   = ($urandom_range(0, 19) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            iv   = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            pend = iv && !rs && !fl && (mq.size() == 2);
            step(rs, fl, iv, cur_pc, cur_inst, ordy);
            check_model($sformatf("rnd%0d", c));
            if (iv && !pend) begin
                cur_pc   = cur_pc + 64'd4;
                cur_inst = $urandom();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
